// File: rtl/gpio_pkg.sv
// Constants shared by the GPIO register block and its input-conditioning stage.
package gpio_pkg;

  localparam logic [1:0] GPIO_MODE_HIZ = 2'b00;
  localparam logic [1:0] GPIO_MODE_OUT = 2'b01;
  localparam logic [1:0] GPIO_MODE_IN  = 2'b10;

  localparam int unsigned GPIO_MAX_PINS = 16;

  // True when a pin's 2-bit mode field selects input mode.
  function automatic logic gpio_is_input(input logic [1:0] mode);
    return mode == GPIO_MODE_IN;
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One pin: pad synchronizer, stability counter, accepted level and edge pulses.
module gpio_debounce_bit #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  input  logic en,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_d, fall_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchronizer runs every clock regardless of pin mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  // Accept a new level only after it differs for DEBOUNCE_CYCLES sync cycles.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (!en) begin
      cnt_d = '0;
    end else if (sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    rise_d = stable_d & ~stable_q;
    fall_d = ~stable_d & stable_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise     <= rise_d;
      fall     <= fall_d;
    end
  end

  assign level = stable_q;

endmodule

// File: rtl/gpio_in_debounce.sv
// GPIO input conditioning: per-pin debounce plus sticky, maskable edge interrupts.
module gpio_in_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_PINS        = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PINS-1:0]   pad_i,
  input  logic [2*NUM_PINS-1:0] mode_i,
  input  logic [NUM_PINS-1:0]   irq_en_i,
  input  logic [NUM_PINS-1:0]   irq_clr_i,
  output logic [NUM_PINS-1:0]   pin_o,
  output logic [NUM_PINS-1:0]   rise_o,
  output logic [NUM_PINS-1:0]   fall_o,
  output logic [NUM_PINS-1:0]   irq_pend_o,
  output logic                  irq_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NUM_PINS-1:0] filt_en;
  logic [NUM_PINS-1:0] pend_d;

  for (genvar k = 0; k < NUM_PINS; k++) begin : g_pin
    assign filt_en[k] = gpio_is_input(mode_i[2*k +: 2]);

    gpio_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk   (clk),
      .rst   (rst),
      .pad   (pad_i[k]),
      .en    (filt_en[k]),
      .level (pin_o[k]),
      .rise  (rise_o[k]),
      .fall  (fall_o[k])
    );
  end

  // A new enabled edge outranks a clear arriving in the same cycle.
  always_comb begin
    pend_d = (irq_pend_o & ~irq_clr_i) | ((rise_o | fall_o) & irq_en_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_pend_o <= '0;
    end else begin
      irq_pend_o <= pend_d;
    end
  end

  assign irq_o = |irq_pend_o;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed, table-driven bench for gpio_in_debounce (2 pins, 2 sync stages, 4-cycle debounce).
module tb_gpio_in_debounce;

  localparam int unsigned NUM_PINS        = 2;
  localparam int unsigned SYNC_STAGES     = 2;
  localparam int unsigned DEBOUNCE_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pad_i;
  logic [3:0] mode_i;
  logic [1:0] irq_en_i;
  logic [1:0] irq_clr_i;
  logic [1:0] pin_o, rise_o, fall_o, irq_pend_o;
  logic       irq_o;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string      tag;
    logic [1:0] pad;
    logic [3:0] mode;
    logic [1:0] en;
    logic [1:0] clr;
    logic [1:0] pin;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] pend;
    logic       irq;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  gpio_in_debounce #(
    .NUM_PINS        (NUM_PINS),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pad_i      (pad_i),
    .mode_i     (mode_i),
    .irq_en_i   (irq_en_i),
    .irq_clr_i  (irq_clr_i),
    .pin_o      (pin_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .irq_pend_o (irq_pend_o),
    .irq_o      (irq_o)
  );

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic cmp(input string name, input logic [1:0] act, input logic [1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] pin, input logic [1:0] rise,
                           input logic [1:0] fall, input logic [1:0] pend, input logic irq);
    cmp({tag, ".pin"},  pin_o,      pin);
    cmp({tag, ".rise"}, rise_o,     rise);
    cmp({tag, ".fall"}, fall_o,     fall);
    cmp({tag, ".pend"}, irq_pend_o, pend);
    cmp({tag, ".irq"},  {1'b0, irq_o}, {1'b0, irq});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input string tag, input logic [1:0] pad, input logic [3:0] mode,
                              input logic [1:0] en, input logic [1:0] clr, input logic [1:0] pin,
                              input logic [1:0] rise, input logic [1:0] fall,
                              input logic [1:0] pend, input logic irq);
    vec_t v;
    v.tag = tag; v.pad = pad; v.mode = mode; v.en = en; v.clr = clr;
    v.pin = pin; v.rise = rise; v.fall = fall; v.pend = pend; v.irq = irq;
    tbl.push_back(v);
  endfunction

  // Both pads high out of reset: both pins rise together at the 6th edge.
  task automatic release_seq(input string tag);
    for (int c = 1; c <= 7; c++) begin
      tick();
      check_all($sformatf("%s.c%0d", tag, c),
                (c >= 6) ? 2'b11 : 2'b00, (c == 6) ? 2'b11 : 2'b00, 2'b00, 2'b00, 1'b0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    pad_i     = 2'b11;
    mode_i    = 4'b1010;
    irq_en_i  = 2'b00;
    irq_clr_i = 2'b00;
    repeat (3) tick();
    check_all("reset_hold", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    rst = 1'b0;
    release_seq("release");

    // Pin0 falls back to 0 so the glitch test starts from a stable low.
    for (int c = 1; c <= 7; c++)
      add($sformatf("fall0.c%0d", c), 2'b10, 4'b1010, 2'b00, 2'b00,
          (c >= 6) ? 2'b10 : 2'b11, 2'b00, (c == 6) ? 2'b01 : 2'b00, 2'b00, 1'b0);
    // Three-cycle high glitch on pad0 peaks at count 3 and is discarded.
    for (int c = 1; c <= 9; c++)
      add($sformatf("glitch.c%0d", c), (c <= 3) ? 2'b11 : 2'b10, 4'b1010, 2'b00, 2'b00,
          2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
    // Clean rise with pin0 interrupt enabled; pending clears on c8.
    for (int c = 1; c <= 9; c++)
      add($sformatf("step.c%0d", c), 2'b11, 4'b1010, 2'b01, (c == 8) ? 2'b01 : 2'b00,
          (c >= 6) ? 2'b11 : 2'b10, (c == 6) ? 2'b01 : 2'b00, 2'b00,
          (c == 7) ? 2'b01 : 2'b00, c == 7);
    // Fall with clear in the same cycle (set wins), enable drop keeps it, then clear.
    for (int c = 1; c <= 10; c++)
      add($sformatf("clrset.c%0d", c), 2'b10, 4'b1010, (c >= 8) ? 2'b00 : 2'b01,
          (c == 7 || c == 9) ? 2'b01 : 2'b00,
          (c >= 6) ? 2'b10 : 2'b11, 2'b00, (c == 6) ? 2'b01 : 2'b00,
          (c == 7 || c == 8) ? 2'b01 : 2'b00, c == 7 || c == 8);

    foreach (tbl[i]) begin
      pad_i     = tbl[i].pad;
      mode_i    = tbl[i].mode;
      irq_en_i  = tbl[i].en;
      irq_clr_i = tbl[i].clr;
      tick();
      check_all(tbl[i].tag, tbl[i].pin, tbl[i].rise, tbl[i].fall, tbl[i].pend, tbl[i].irq);
    end
    irq_clr_i = 2'b00;

    // Output mode: pad0 toggles but the frozen level and interrupts stay quiet.
    mode_i   = 4'b0001;
    irq_en_i = 2'b11;
    for (int i = 0; i < 20; i++) begin
      pad_i = (i % 2 == 0) ? 2'b11 : 2'b10;
      tick();
      check_all($sformatf("gate.t%0d", i), 2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
    end
    pad_i = 2'b10;
    repeat (3) begin
      tick();
      check_all("gate.settle", 2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
    end
    mode_i = 4'b0010;
    pad_i  = 2'b11;
    for (int c = 1; c <= 7; c++) begin
      tick();
      check_all($sformatf("regate.c%0d", c), (c >= 6) ? 2'b11 : 2'b10,
                (c == 6) ? 2'b01 : 2'b00, 2'b00, (c == 7) ? 2'b01 : 2'b00, c == 7);
    end

    // Mid-count reset: pin0 has counted 2 differing cycles, pending still set.
    mode_i   = 4'b1010;
    irq_en_i = 2'b00;
    pad_i    = 2'b10;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_all($sformatf("precount.c%0d", c), 2'b11, 2'b00, 2'b00, 2'b01, 1'b1);
    end
    #2;
    rst = 1'b1;
    #1;
    check_all("midreset", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    pad_i = 2'b11;
    repeat (2) tick();
    rst = 1'b0;
    release_seq("rerelease");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
